// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO write-side bundle for fifo_wr_arbiter.
// The master modport is the environment: the producers and the FIFO flags.
// The slave modport is the arbiter itself.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_overflow;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;

  modport master (
    output req_valid, req_data, fifo_full, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_data_in
  );

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port
// between NUM_REQ producers, in bursts of up to BURST_MAX beats per grant.
// Each new grant costs one IDLE bubble cycle. FIFO full stalls the current
// burst without ending it.
// Optional macro FIFO_ARB_STATS_EN adds saturating 16-bit per-requester
// accepted-beat counters on stat_cnt. When the macro is undefined,
// stat_cnt is tied to zero.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  fifo_wr_arbiter_if.slave           bus,
  output logic                       grant_active,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_overflow,
  output logic [NUM_REQ*16-1:0]      stat_cnt
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_MAX - 1);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               state_r, state_s;
  logic [IDW-1:0]       rr_ptr_r, rr_ptr_s;
  logic [IDW-1:0]       grant_id_r, grant_id_s;
  logic [BCW-1:0]       beat_cnt_r, beat_cnt_s;
  logic                 err_overflow_r;
  logic [IDW-1:0]       sel_s;
  logic                 any_valid_s;
  logic                 transfer_s;
  logic [NUM_REQ-1:0]   ready_s;
  logic [DATA_WIDTH-1:0] data_s;
  int                   idx_v;

  // Round-robin search: the first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    sel_s       = '0;
    any_valid_s = 1'b0;
    idx_v       = 0;
    // Walk downward so that the lowest offset from rr_ptr is written last and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_v = int'(rr_ptr_r) + k;
      if (idx_v >= NUM_REQ) begin
        idx_v = idx_v - NUM_REQ;
      end else begin
        idx_v = idx_v;
      end
      if (bus.req_valid[idx_v]) begin
        sel_s       = idx_v[IDW-1:0];
        any_valid_s = 1'b1;
      end else begin
        sel_s       = sel_s;
      end
    end
  end

  // Write-data mux of the granted requester. It is always defined, never X.
  always_comb begin
    data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_r == IDW'(i)) begin
        data_s = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        data_s = data_s;
      end
    end
  end

  // FSM next state, burst bookkeeping and handshake outputs.
  always_comb begin
    state_s    = state_r;
    rr_ptr_s   = rr_ptr_r;
    grant_id_s = grant_id_r;
    beat_cnt_s = beat_cnt_r;
    ready_s    = '0;
    transfer_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          grant_id_s = sel_s;
          beat_cnt_s = '0;
          state_s    = ST_BURST;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_BURST: begin
        ready_s[grant_id_r] = !bus.fifo_full;
        transfer_s          = bus.req_valid[grant_id_r] && !bus.fifo_full;
        if (transfer_s) begin
          beat_cnt_s = beat_cnt_r + BCW'(1);
          if (beat_cnt_r == BEAT_LAST) begin
            state_s  = ST_IDLE;
            rr_ptr_s = (grant_id_r == ID_LAST) ? '0 : grant_id_r + IDW'(1);
          end else begin
            state_s  = ST_BURST;
          end
        end else if (!bus.req_valid[grant_id_r]) begin
          // The producer has gone idle, so release the port.
          state_s  = ST_IDLE;
          rr_ptr_s = (grant_id_r == ID_LAST) ? '0 : grant_id_r + IDW'(1);
        end else begin
          // FIFO full: hold the burst, do not count the beat.
          state_s  = ST_BURST;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Arbiter state registers and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      rr_ptr_r       <= '0;
      grant_id_r     <= '0;
      beat_cnt_r     <= '0;
      err_overflow_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      rr_ptr_r       <= rr_ptr_s;
      grant_id_r     <= grant_id_s;
      beat_cnt_r     <= beat_cnt_s;
      err_overflow_r <= err_overflow_r | bus.fifo_overflow;
    end
  end

  assign bus.req_ready    = ready_s;
  assign bus.fifo_wr_en   = transfer_s;
  assign bus.fifo_data_in = data_s;
  assign grant_active     = (state_r == ST_BURST);
  assign grant_id         = grant_id_r;
  assign err_overflow     = err_overflow_r;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_r [NUM_REQ];

  // Saturating count of words accepted from each requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_r[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (transfer_s && (grant_id_r == IDW'(i)) && (stat_r[i] != 16'hFFFF)) begin
          stat_r[i] <= stat_r[i] + 16'h0001;
        end else begin
          stat_r[i] <= stat_r[i];
        end
      end
    end
  end

  // Pack the counters onto the flat status bus.
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_cnt[i*16 +: 16] = stat_r[i];
    end
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. Producer models offer
// base+n words. Each test pushes the expected FIFO word order and grant
// order to queues. The tick task pops and compares them whenever the DUT
// writes or starts a burst.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus();

  logic              grant_active;
  logic [1:0]        grant_id;
  logic              err_overflow;
  logic [NR*16-1:0]  stat_cnt;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .err_overflow (err_overflow),
    .stat_cnt     (stat_cnt)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_data_q[$];
  logic [1:0] exp_grant_q[$];

  logic [NR-1:0] en;
  int            sent[NR];
  int            limit[NR];
  logic [7:0]    base[NR];
  int            words[NR];
  int            cyc, wr_cnt, first_wr, last_wr;
  logic          prev_active;

  task automatic drive_producers();
    logic [NR-1:0]    v;
    logic [NR*DW-1:0] d;
    for (int i = 0; i < NR; i++) begin
      v[i]          = en[i] && (sent[i] < limit[i]);
      d[i*DW +: DW] = base[i] + 8'(sent[i]);
    end
    bus.req_valid = v;
    bus.req_data  = d;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the producers after the edge.
  task automatic tick();
    logic [NR-1:0] acc;
    logic [7:0]    e_d;
    logic [1:0]    e_g;
    @(negedge clk);
    cyc++;
    if (grant_active && !prev_active) begin
      checks++;
      if (exp_grant_q.size() == 0) begin
        failures++;
        $display("FAIL grant_order: got grant %0d, required no further grant", grant_id);
      end else begin
        e_g = exp_grant_q.pop_front();
        if (grant_id !== e_g) begin
          failures++;
          $display("FAIL grant_order: got grant %0d, required %0d", grant_id, e_g);
        end
      end
    end
    prev_active = grant_active;
    if (bus.fifo_wr_en === 1'b1) begin
      checks++;
      if (bus.fifo_full !== 1'b0) begin
        failures++;
        $display("FAIL wr_while_full: got wr_en=1 with fifo_full=1, required wr_en=0");
      end
      checks++;
      if (exp_data_q.size() == 0) begin
        failures++;
        $display("FAIL fifo_data: got extra word %h, required no write", bus.fifo_data_in);
      end else begin
        e_d = exp_data_q.pop_front();
        if (bus.fifo_data_in !== e_d) begin
          failures++;
          $display("FAIL fifo_data: got %h, required %h", bus.fifo_data_in, e_d);
        end
      end
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        sent[i]++;
        words[i]++;
      end
    end
    drive_producers();
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    en  = '0;
    for (int i = 0; i < NR; i++) begin
      sent[i] = 0; limit[i] = 0; base[i] = 8'h00; words[i] = 0;
    end
    bus.fifo_full     = 1'b0;
    bus.fifo_overflow = 1'b0;
    drive_producers();
    exp_data_q.delete();
    exp_grant_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b1;
    prev_active = 1'b0;
    wr_cnt      = 0;
    first_wr    = -1;
    last_wr     = -1;
    cyc         = 0;
  endtask

  // Run until both scoreboards are empty, then run a few extra cycles to catch stray writes.
  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_data_q.size() != 0 || exp_grant_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_data_q.size() != 0 || exp_grant_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d words/%0d grants outstanding, required 0/0",
               name, exp_data_q.size(), exp_grant_q.size());
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en  = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      sent[i] = 0; limit[i] = 8; base[i] = 8'(i * 16);
    end
    bus.fifo_full     = 1'b0;
    bus.fifo_overflow = 1'b0;
    drive_producers();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.fifo_wr_en !== 1'b0 || grant_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: got ready=%b wr_en=%b active=%b, required 0000 0 0",
               bus.req_ready, bus.fifo_wr_en, grant_active);
    end
    checks++;
    if (grant_id !== 2'd0 || err_overflow !== 1'b0 || stat_cnt !== '0) begin
      failures++;
      $display("FAIL reset_state: got grant_id=%0d err=%b stat=%h, required 0 0 0",
               grant_id, err_overflow, stat_cnt);
    end
    checks++;
    if ($isunknown(bus.fifo_data_in)) begin
      failures++;
      $display("FAIL reset_data_x: got %h, required a known value", bus.fifo_data_in);
    end
  endtask

  task automatic test_single();
    reset_dut();
    en = 4'b0001; limit[0] = 8; base[0] = 8'h10;
    drive_producers();
    for (int k = 0; k < 8; k++) exp_data_q.push_back(8'(8'h10 + k));
    exp_grant_q.push_back(2'd0);
    exp_grant_q.push_back(2'd0);
    drain(40, "single");
    checks++;
    if (wr_cnt != 8) begin
      failures++;
      $display("FAIL single_count: got %0d writes, required 8", wr_cnt);
    end
    checks++;
    if (last_wr - first_wr != 8) begin
      failures++;
      $display("FAIL single_span: got %0d cycles first-to-last, required 8", last_wr - first_wr);
    end
  endtask

  task automatic test_all_rr();
    reset_dut();
    en = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      limit[i] = 8; base[i] = 8'(i * 16);
    end
    drive_producers();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) begin
        exp_grant_q.push_back(2'(i));
        for (int k = 0; k < BM; k++) exp_data_q.push_back(8'(i * 16 + r * 4 + k));
      end
    end
    drain(120, "all_rr");
    checks++;
    if (wr_cnt != 32) begin
      failures++;
      $display("FAIL all_rr_count: got %0d writes, required 32", wr_cnt);
    end
    checks++;
    if (last_wr - first_wr != 38) begin
      failures++;
      $display("FAIL all_rr_span: got %0d cycles first-to-last, required 38", last_wr - first_wr);
    end
    repeat (8) tick();
    for (int i = 0; i < NR; i++) begin
      checks++;
`ifdef FIFO_ARB_STATS_EN
      if (stat_cnt[i*16 +: 16] !== 16'(words[i])) begin
        failures++;
        $display("FAIL stat_cnt%0d: got %0d, required %0d", i, stat_cnt[i*16 +: 16], words[i]);
      end
`else
      if (stat_cnt[i*16 +: 16] !== 16'h0000) begin
        failures++;
        $display("FAIL stat_cnt%0d: got %0d, required 0", i, stat_cnt[i*16 +: 16]);
      end
`endif
    end
  endtask

  task automatic test_full_stall();
    int n;
    reset_dut();
    en = 4'b0100; limit[2] = 4; base[2] = 8'h20;
    drive_producers();
    for (int k = 0; k < 4; k++) exp_data_q.push_back(8'(8'h20 + k));
    exp_grant_q.push_back(2'd2);
    n = 0;
    while (wr_cnt < 2 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (wr_cnt != 2) begin
      failures++;
      $display("FAIL full_reach: got %0d writes, required 2", wr_cnt);
    end
    bus.fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #2;
      checks++;
      if (bus.req_ready[2] !== 1'b0 || bus.fifo_wr_en !== 1'b0 || grant_active !== 1'b1) begin
        failures++;
        $display("FAIL full_stall: got ready2=%b wr_en=%b active=%b, required 0 0 1",
                 bus.req_ready[2], bus.fifo_wr_en, grant_active);
      end
      tick();
    end
    bus.fifo_full = 1'b0;
    drain(20, "full");
    checks++;
    if (wr_cnt != 4) begin
      failures++;
      $display("FAIL full_count: got %0d writes, required 4", wr_cnt);
    end
  endtask

  task automatic test_drop();
    reset_dut();
    en = 4'b1010;
    limit[1] = 2; base[1] = 8'h10;
    limit[3] = 4; base[3] = 8'h30;
    drive_producers();
    exp_grant_q.push_back(2'd1);
    exp_grant_q.push_back(2'd3);
    exp_data_q.push_back(8'h10);
    exp_data_q.push_back(8'h11);
    for (int k = 0; k < 4; k++) exp_data_q.push_back(8'(8'h30 + k));
    drain(40, "drop");
    checks++;
    if (wr_cnt != 6) begin
      failures++;
      $display("FAIL drop_count: got %0d writes, required 6", wr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    reset_dut();
    en = 4'b1000; limit[3] = 8; base[3] = 8'h30;
    drive_producers();
    exp_grant_q.push_back(2'd3);
    exp_data_q.push_back(8'h30);
    exp_data_q.push_back(8'h31);
    n = 0;
    while (wr_cnt < 2 && n < 20) begin
      tick();
      n++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (grant_active !== 1'b0 || bus.fifo_wr_en !== 1'b0 || bus.req_ready !== 4'b0000 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid: got active=%b wr_en=%b ready=%b grant_id=%0d, required 0 0 0000 0",
               grant_active, bus.fifo_wr_en, bus.req_ready, grant_id);
    end
    exp_data_q.delete();
    exp_grant_q.delete();
    en = 4'b1010; limit[1] = 1; base[1] = 8'h50;
    drive_producers();
    exp_grant_q.push_back(2'd1);
    exp_grant_q.push_back(2'd3);
    exp_grant_q.push_back(2'd3);
    exp_data_q.push_back(8'h50);
    for (int k = 2; k < 8; k++) exp_data_q.push_back(8'(8'h30 + k));
    @(posedge clk);
    #1;
    checks++;
    if (bus.fifo_wr_en !== 1'b0 || grant_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got wr_en=%b active=%b, required 0 0", bus.fifo_wr_en, grant_active);
    end
    rst         = 1'b1;
    prev_active = 1'b0;
    drain(60, "reset_mid");
  endtask

  task automatic test_overflow();
    reset_dut();
    checks++;
    if (err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_init: got %b, required 0", err_overflow);
    end
    bus.fifo_overflow = 1'b1;
    tick();
    bus.fifo_overflow = 1'b0;
    checks++;
    if (err_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: got %b, required 1", err_overflow);
    end
    repeat (5) tick();
    checks++;
    if (err_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: got %b, required 1", err_overflow);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got %b, required 0", err_overflow);
    end
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_all_rr();
    test_full_stall();
    test_drop();
    test_reset_mid();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one fifo_sync_top write port between NUM_REQ producers.
- Grants one requester at a time for bursts of up to BURST_MAX beats.
- Drives the FIFO wr_en/data_in and backpressures producers on FIFO full.
- Sits directly in front of fifo_sync_top. Read side is untouched.

Parameters:
NUM_REQ, 4, number of producers (>=2)
DATA_WIDTH, 8, word width; matches the FIFO DATA_WIDTH
BURST_MAX, 4, max beats per grant before forced re-arbitration (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  NUM_REQ  per-producer word valid
req_data  in  NUM_REQ*DATA_WIDTH  producer words; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  per-producer accept; a transfer occurs when valid&&ready
fifo_full  in  1  FIFO full flag
fifo_overflow  in  1  FIFO overflow pulse
fifo_wr_en  out  1  FIFO write enable
fifo_data_in  out  DATA_WIDTH  FIFO write data
grant_active  out  1  high while in BURST
grant_id  out  $clog2(NUM_REQ)  current/last granted requester
err_overflow  out  1  sticky overflow error
stat_cnt  out  NUM_REQ*16  per-requester accepted-beat counters (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, err_overflow=0, stat_cnt=0. Combinational outputs then resolve to req_ready=0, fifo_wr_en=0, grant_active=0.
- fifo_data_in is a mux of the granted requester's data. It is don't-care when fifo_wr_en=0, but the RTL must not produce X.
- FSM states are IDLE and BURST. State, rr_ptr, grant_id and beat_cnt are registered.
- IDLE:
  - req_ready=0.
  - If any req_valid: select the first i with req_valid[i], searching from rr_ptr upward with wrap mod NUM_REQ.
  - Load grant_id=i and beat_cnt=0, then go to BURST next cycle. Arbitration costs 1 bubble cycle.
- BURST:
  - req_ready[grant_id] = !fifo_full. All other ready bits are 0.
  - transfer = req_valid[grant_id] && !fifo_full. fifo_wr_en=transfer (combinational, same cycle).
  - On transfer: beat_cnt++.
  - Exit to IDLE next cycle when:
    - transfer && beat_cnt==BURST_MAX-1, or
    - !req_valid[grant_id] (producer idle; no transfer that cycle).
  - fifo_full stalls the burst. It does not count beats and does not force exit.
  - On exit: rr_ptr = (grant_id+1) mod NUM_REQ. grant_id holds its value.
- Fairness: a continuously-valid requester waits at most (NUM_REQ-1)*(BURST_MAX+1) cycles plus FIFO-full stall time.
- fifo_wr_en is never asserted while fifo_full=1.
- err_overflow: set on any fifo_overflow=1. Cleared only by reset.
- fifo_full rising mid-burst: ready drops the same cycle, with no lost or duplicated words.
- Reset asserted mid-burst: immediate return to IDLE and rr_ptr=0. A partially sent burst is not resumed.

Optional Feature:
Macro FIFO_ARB_STATS_EN.
- Defined: stat_cnt[i*16 +: 16] increments on each transfer from requester i and saturates at 16'hFFFF. Cleared by reset.
- Undefined: no counter flops; stat_cnt is tied to 0.

Test Plan:
1. Single requester: req_valid=4'b0001, data 8'h10..8'h17 (8 words), FIFO not full.
   -> BURST 10,11,12,13; 1 IDLE cycle; then 14..17.
   -> fifo_wr_en high 8 cycles, grant_id=0 throughout.
2. All four valid continuously, req i sends 8'hi0.. from power-up.
   -> Grant order 0,1,2,3,0.
   -> Each burst exactly 4 beats, one bubble between bursts; FIFO receives 00,01,02,03,10,11,12,13,20,...
3. Req 2 in burst, fifo_full forced high 3 cycles after beat 2.
   -> req_ready[2]=0 and fifo_wr_en=0 for those 3 cycles.
   -> Beats 3-4 follow after full drops; total 4 words, no duplicates.
4. Req 1 valid for 2 words then drops.
   -> Burst ends after 2 beats; next grant goes to the next valid requester after 1 (e.g. 3 if only 3 is valid).
5. rst pulsed low mid-burst of req 3.
   -> Outputs zero asynchronously; after release, first grant goes to lowest valid index starting at 0.
6. Pulse fifo_overflow once.
   -> err_overflow=1 and stays high until rst.
   -> With FIFO_ARB_STATS_EN: after scenario 2 plus 8 more cycles, stat_cnt matches per-requester FIFO word counts.
